ql_key_injector: RTL and testbench
==================================

# ql_key_injector

- Schedules synthetic key-press sequences into the 8x8 QL keyboard matrix, for OSD paste, autotype and joystick macros.
- Sits between the PS/2 keyboard matrix source and the IPC-facing matrix; the live matrix passes through and is OR'd with injected keys.
- Requests are queued in a FIFO and played out one at a time. Each request runs the sequence modifier → modifier+key → release → gap, with tick-based timing, so the QL accepts combined keys.

## Interface
Parameters:
- TICK_DIV, 1024: clk cycles per tick (≥2)
- MOD_TICKS, 15: ticks modifiers are held before the main key (≥1)
- HOLD_TICKS, 40: ticks modifier+key are held (≥1)
- GAP_TICKS, 20: ticks all-released before the next request (≥1)
- FIFO_DEPTH, 8: request FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept (not full and not flush)
- req_key  in  6  matrix index, row*8+col
- req_mod  in  3  {alt, ctrl, shift}
- flush  in  1  discard queue and abort the current sequence
- kbd_matrix  in  64  live matrix from the keyboard decoder
- matrix  out  64  kbd_matrix | inj_q
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Accept: a request is pushed when req_valid && req_ready. The FIFO entry is {req_mod, req_key}.
- inj_q is a registered 64-bit injection vector. Modifier bits are 56 (shift), 57 (ctrl) and 58 (alt).
- FSM states: IDLE, MOD, KEY, REL, GAP.
  - IDLE: if the FIFO is non-empty (and not deferred, see Configuration), pop the head. Go to MOD if req_mod≠0, else KEY.
  - MOD: inj_q = modifier bits only, for MOD_TICKS ticks, then KEY.
  - KEY: inj_q = modifier bits | bit[req_key], for HOLD_TICKS ticks, then REL.
  - REL: inj_q = 0 for one cycle, then GAP. Key and modifiers are released together.
  - GAP: inj_q = 0 for GAP_TICKS ticks, then IDLE.
- Prescaler and tick counter restart on every state entry, so a state of N ticks lasts exactly N*TICK_DIV cycles.
- Once MOD/KEY has started, a sequence always runs to completion. Only flush or reset aborts it.
- flush:
  - takes effect the same cycle: FIFO emptied and inj_q cleared next edge;
  - from MOD or KEY, go to GAP (full GAP_TICKS); from REL or GAP, stay on the normal path; from IDLE, stay in IDLE.
- Simultaneous flush and req_valid: req_ready=0, so the request is not accepted.
- Simultaneous push and pop in IDLE with FIFO count 1: both happen, and the count stays 1.
- FIFO full: req_ready=0. Pushes are refused; nothing is overwritten.
- Duplicate bits: if a live key equals an injected key, matrix shows it set (OR); no error.

## Timing
- Reset values:
  - state=IDLE, inj_q=0, FIFO empty;
  - req_ready=1, busy=0;
  - matrix=kbd_matrix (combinational pass-through).
- Reset mid-sequence clears inj_q asynchronously.
- Request latency, with an empty FIFO and state IDLE:
  - push at edge t;
  - IDLE sees non-empty at t+1 and pops;
  - inj_q changes at t+2.
- The matrix path from kbd_matrix is combinational, with no added latency. The inj_q contribution is registered.
- busy rises the cycle after a push. It falls on the edge that enters IDLE with the FIFO empty.

## Configuration
- Macro: KEY_INJECT_DEFER_EN.
  - Defined: IDLE does not pop while kbd_matrix≠0. The live keyboard has priority, and injection waits until all live keys are released.
  - Undefined: IDLE pops regardless of kbd_matrix.
- MOD/KEY/REL/GAP are unaffected in both cases.

## Structure
- Package ql_kbd_pkg holds:
  - matrix index constants (row/col helpers, SHIFT_IDX=56, CTRL_IDX=57, ALT_IDX=58);
  - the FSM state enum;
  - the request struct {mod[2:0], key[5:0]}.
- One sub-module: key_inject_fifo. It is a synchronous FIFO with push/pop/flush, full/empty flags and a count, and uses async reset.
- The top level holds the FSM, the prescaler, the tick counter and the output OR.

## Test plan
Bench parameters: TICK_DIV=4, MOD_TICKS=2, HOLD_TICKS=3, GAP_TICKS=2.
- Plain key:
  - Stimulus: req_key=44 ('a'), req_mod=0, kbd_matrix=0.
  - Response: no modifier phase; bit 44 is set for exactly 12 cycles starting at t+2; then 1+8 cycles of zero; busy then drops.
- Shifted key:
  - Stimulus: req_key=44, req_mod=3'b001.
  - Response: bit 56 alone for 8 cycles; then bits 56+44 for 12 cycles; then both clear on the same edge.
- FIFO full:
  - Stimulus: push 9 requests back-to-back while deferred (kbd_matrix=1).
  - Response: req_ready=0 after 8 pushes; the 9th is not accepted.
  - Check: with KEY_INJECT_DEFER_EN defined, nothing plays until kbd_matrix=0, then 8 sequences play in order.
- Flush:
  - Stimulus: flush asserted in KEY with 3 requests queued.
  - Response: inj_q=0 next edge; 8 GAP cycles; then IDLE with busy=0; the queued requests are never played.
- Reset mid-sequence:
  - Stimulus: reset asserted during MOD.
  - Response: matrix equals kbd_matrix immediately (async); req_ready=1.
- Pass-through:
  - Stimulus: kbd_matrix=64'h0000_0000_0000_0002 during an injection of key 44.
  - Response: matrix=kbd_matrix|bit44.

Source files
------------

// File: rtl/ql_kbd_pkg.sv
// ql_kbd_pkg: shared QL keyboard matrix indices, injector state enum and request type
package ql_kbd_pkg;
  localparam int SHIFT_IDX = 56;
  localparam int CTRL_IDX = 57;
  localparam int ALT_IDX = 58;
  typedef enum logic [2:0] {IDLE, MOD, KEY, REL, GAP} inj_state_t;
  typedef struct packed {
    logic [2:0] mod;
    logic [5:0] key;
  } inj_req_t;
  function automatic logic [5:0] key_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction
  function automatic logic [2:0] key_row(input logic [5:0] k);
    return k[5:3];
  endfunction
  function automatic logic [2:0] key_col(input logic [5:0] k);
    return k[2:0];
  endfunction
  function automatic logic [63:0] inj_vec(input inj_req_t r, input logic with_key);
    logic [63:0] v;
    v = '0;
    v[SHIFT_IDX] = r.mod[0];
    v[CTRL_IDX] = r.mod[1];
    v[ALT_IDX] = r.mod[2];
    v[r.key] = v[r.key] | with_key;
    return v;
  endfunction
endpackage

// File: rtl/key_inject_fifo.sv
// key_inject_fifo: request FIFO with push/pop/flush, full/empty flags and occupancy count
module key_inject_fifo
  import ql_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  inj_req_t      din,
  output inj_req_t      dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  inj_req_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/ql_key_injector.sv
// ql_key_injector: queues synthetic key presses and ORs them into the live 8x8 QL matrix
// ports: req_valid/req_ready/req_key/req_mod request in, flush abort, kbd_matrix live in,
// matrix = kbd_matrix | inj_q out, busy. Option KEY_INJECT_DEFER_EN holds off popping while keys are live.
module ql_key_injector
  import ql_kbd_pkg::*;
#(
  parameter int TICK_DIV = 1024,
  parameter int MOD_TICKS = 15,
  parameter int HOLD_TICKS = 40,
  parameter int GAP_TICKS = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_key,
  input  logic [2:0]  req_mod,
  input  logic        flush,
  input  logic [63:0] kbd_matrix,
  output logic [63:0] matrix,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int MAXT = (MOD_TICKS > HOLD_TICKS) ? ((MOD_TICKS > GAP_TICKS) ? MOD_TICKS : GAP_TICKS)
                                                 : ((HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS);
  localparam int TW = $clog2(MAXT + 1);
  inj_state_t state;
  inj_req_t cur, head;
  logic [63:0] inj_q;
  logic [PW-1:0] pre;
  logic [TW-1:0] ticks, target;
  logic [CW-1:0] count;
  logic full, empty, pop, defer, tick, done;
`ifdef KEY_INJECT_DEFER_EN
  assign defer = |kbd_matrix;
`else
  assign defer = 1'b0;
`endif
  assign req_ready = !full && !flush;
  assign busy = state != IDLE || count != '0;
  assign matrix = kbd_matrix | inj_q;
  always_comb begin
    tick = pre == PW'(TICK_DIV - 1);
    target = state == MOD ? TW'(MOD_TICKS - 1) : state == KEY ? TW'(HOLD_TICKS - 1) : TW'(GAP_TICKS - 1);
    done = tick && ticks == target;
    pop = state == IDLE && !empty && !flush && !defer;
  end
  key_inject_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(req_valid && req_ready),
    .pop(pop),
    .flush(flush),
    .din({req_mod, req_key}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // inj_q follows the state of the previous cycle, so a popped request shows two edges after its push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      inj_q <= '0;
      pre <= '0;
      ticks <= '0;
    end else begin
      inj_q <= (flush || !(state == MOD || state == KEY)) ? '0 : inj_vec(cur, state == KEY);
      pre <= tick ? '0 : pre + 1'b1;
      ticks <= tick ? ticks + 1'b1 : ticks;
      case (state)
        IDLE: if (pop) begin
          cur <= head;
          state <= head.mod != '0 ? MOD : KEY;
          pre <= '0;
          ticks <= '0;
        end
        MOD: if (flush || done) begin
          state <= flush ? GAP : KEY;
          pre <= '0;
          ticks <= '0;
        end
        KEY: if (flush || done) begin
          state <= flush ? GAP : REL;
          pre <= '0;
          ticks <= '0;
        end
        REL: begin
          state <= GAP;
          pre <= '0;
          ticks <= '0;
        end
        GAP: if (done) begin
          state <= IDLE;
          pre <= '0;
          ticks <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ql_key_injector.sv
// tb_ql_key_injector: directed and random checks of ql_key_injector against a timeline model
module tb_ql_key_injector;
  localparam int TD = 4, MT = 2, HT = 3, GT = 2;
`ifdef KEY_INJECT_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, flush = 1'b0;
  logic req_ready, busy;
  logic [5:0] req_key = '0;
  logic [2:0] req_mod = '0;
  logic [63:0] kbd_matrix = '0, matrix;
  int total = 0, bad = 0;
  logic [8:0] q[$];
  logic [8:0] r = '0;
  int n = 0, p = -100000, m = 0, k = 0, cut = 0, idle_at = 0, seq_end = 0;
  int c1, c2, c3, obs_acc;

  always #5 clk = ~clk;

  ql_key_injector #(.TICK_DIV(TD), .MOD_TICKS(MT), .HOLD_TICKS(HT), .GAP_TICKS(GT), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_mod(req_mod), .flush(flush), .kbd_matrix(kbd_matrix), .matrix(matrix), .busy(busy)
  );

  // expected injection after edge e: modifiers for m cycles, modifiers+key for k cycles, else nothing
  function automatic logic [63:0] exp_inj(input int e);
    logic [63:0] mods, key;
    int o;
    o = e - p;
    mods = 64'(r[8:6]) << 56;
    key = 64'd1 << r[5:0];
    if (e >= cut) return '0;
    if (o >= 1 && o <= m) return mods;
    if (o > m && o <= m + k) return mods | key;
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit idle, ready, pop;
    int e;
    #1;
    e = n + 1;
    ready = q.size() < 8 && !flush;
    chk("req_ready", 64'(req_ready), 64'(ready));
    chk("matrix_comb", matrix, kbd_matrix | exp_inj(n));
    idle = n >= idle_at;
    pop = idle && q.size() > 0 && !flush && !(DEFER && kbd_matrix != '0);
    if (flush) begin
      if (!idle && n < seq_end) idle_at = e + GT * TD;
      seq_end = 0;
      cut = e;
      q.delete();
    end else if (pop) begin
      r = q.pop_front();
      p = e;
      m = r[8:6] != '0 ? MT * TD : 0;
      k = HT * TD;
      seq_end = p + m + k;
      cut = 1 << 30;
      idle_at = p + m + k + 1 + GT * TD;
    end
    if (req_valid && ready) q.push_back({req_mod, req_key});
    @(posedge clk);
    n = e;
    #1;
    chk("matrix", matrix, kbd_matrix | exp_inj(n));
    chk("busy", 64'(busy), 64'((n < idle_at) || q.size() > 0));
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (n >= idle_at && q.size() == 0) break;
      step();
    end
    chk("drain_busy", 64'(busy), 64'(0));
  endtask

  task automatic push(input logic [5:0] key, input logic [2:0] mod);
    req_valid = 1'b1;
    req_key = key;
    req_mod = mod;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    kbd_matrix = 64'h0123_4567_89ab_cdef;
    #23 reset = 1'b0;
    #1;
    chk("reset_matrix", matrix, 64'h0123_4567_89ab_cdef);
    chk("reset_ready", 64'(req_ready), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    kbd_matrix = '0;

    push(6'd44, 3'b000);
    c1 = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (matrix[44]) c1++;
    end
    chk("plain_hold_cycles", 64'(c1), 64'(12));
    drain(50);

    push(6'd44, 3'b001);
    c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (matrix[56] && !matrix[44]) c1++;
      if (matrix[56] && matrix[44]) c2++;
      if (!matrix[56] && matrix[44]) c3++;
    end
    chk("shift_mod_cycles", 64'(c1), 64'(8));
    chk("shift_both_cycles", 64'(c2), 64'(12));
    chk("shift_key_alone", 64'(c3), 64'(0));
    drain(50);

    push(6'd44, 3'b000);
    step();
    kbd_matrix = 64'h2;
    step();
    chk("pass_through", matrix, 64'h2 | (64'd1 << 44));
    for (int i = 0; i < 5; i++) step();
    kbd_matrix = '0;
    drain(50);

    kbd_matrix = 64'h1;
    obs_acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_key = 6'(i + 10);
      req_mod = 3'(i);
      #1;
      if (req_ready) obs_acc++;
      step();
    end
    req_valid = 1'b0;
    chk("full_accepted", 64'(obs_acc), DEFER ? 64'(8) : 64'(9));
    chk("full_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 10; i++) step();
    kbd_matrix = '0;
    drain(600);

    push(6'd20, 3'b000);
    push(6'd21, 3'b010);
    push(6'd22, 3'b100);
    push(6'd23, 3'b001);
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    req_valid = 1'b1;
    req_key = 6'd30;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_clears", matrix, 64'd0);
    c1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (matrix != '0) c1++;
    end
    chk("flush_no_replay", 64'(c1), 64'(0));
    chk("flush_idle", 64'(busy), 64'(0));

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 3) == 0;
      req_key = 6'($urandom);
      req_mod = 3'($urandom);
      flush = ($urandom % 50) == 0;
      kbd_matrix = ($urandom % 5) == 0 ? (64'd1 << $urandom_range(63)) : 64'd0;
      step();
    end
    req_valid = 1'b0;
    flush = 1'b0;
    kbd_matrix = '0;
    drain(600);

    push(6'd33, 3'b010);
    for (int i = 0; i < 3; i++) step();
    chk("rst_in_mod", matrix, 64'd1 << 57);
    kbd_matrix = 64'h0000_0100_0000_0040;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_matrix", matrix, 64'h0000_0100_0000_0040);
    chk("rst_async_ready", 64'(req_ready), 64'(1));
    q.delete();
    idle_at = n;
    cut = 0;
    seq_end = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    kbd_matrix = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 5; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
